// File: rtl/axil_reg_access_arbiter.sv
// Two-requester round-robin arbiter driving a single AXI4-Lite master port.
// Optional per-requester access/error counters are built when AXIL_ARB_STATS_EN is defined.
module axil_reg_access_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  output logic [1:0]            ack,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            resp,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  output logic [2:0]            dbg_state
`ifdef AXIL_ARB_STATS_EN
  ,
  output logic [2*16-1:0]       wr_cnt,
  output logic [2*16-1:0]       rd_cnt,
  output logic [15:0]           err_cnt
`endif
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_ADDR = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [2:0]        state;
  logic              last_grant;
  logic              grant;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q;

  logic              gnt_next;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              aw_done, w_done;

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where VALID and READY are both high; VALID and its payload stay put until then.
  always_comb begin
    gnt_next  = (req == 2'b11) ? ~last_grant : req[1];
    sel_addr  = gnt_next ? addr[2*ADDR_W-1:ADDR_W]  : addr[ADDR_W-1:0];
    sel_wdata = gnt_next ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    aw_done   = !aw_valid_q || M_AXI_AWREADY;
    w_done    = !w_valid_q  || M_AXI_WREADY;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      ack        <= 2'b00;
      rdata      <= '0;
      resp       <= 2'b00;
    end else begin
      ack <= 2'b00;
      case (state)
        IDLE: begin
          if (|req) begin
            grant      <= gnt_next;
            last_grant <= gnt_next;
            lat_addr   <= sel_addr & ADDR_MASK;
            lat_wdata  <= sel_wdata;
            if (we[gnt_next]) begin
              state      <= WR_ADDR;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
            end else begin
              state      <= RD_ADDR;
              ar_valid_q <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          // Address and data channels retire independently; leave once both have.
          if (aw_valid_q && M_AXI_AWREADY) aw_valid_q <= 1'b0;
          if (w_valid_q && M_AXI_WREADY)   w_valid_q  <= 1'b0;
          if (aw_done && w_done) begin
            state     <= WR_RESP;
            b_ready_q <= 1'b1;
          end
        end
        WR_RESP: begin
          if (M_AXI_BVALID) begin
            resp      <= M_AXI_BRESP;
            rdata     <= '0;
            b_ready_q <= 1'b0;
            ack       <= grant ? 2'b10 : 2'b01;
            state     <= DONE;
          end
        end
        RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state      <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (M_AXI_RVALID) begin
            rdata     <= M_AXI_RDATA;
            resp      <= M_AXI_RRESP;
            r_ready_q <= 1'b0;
            ack       <= grant ? 2'b10 : 2'b01;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign M_AXI_AWADDR  = lat_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = aw_valid_q;
  assign M_AXI_WDATA   = lat_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = w_valid_q;
  assign M_AXI_BREADY  = b_ready_q;
  assign M_AXI_ARADDR  = lat_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = ar_valid_q;
  assign M_AXI_RREADY  = r_ready_q;
  assign dbg_state     = state;

`ifdef AXIL_ARB_STATS_EN
  logic lat_we;

  // Counters advance in the DONE cycle, when ack and resp describe the finished access.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      lat_we  <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (state == IDLE && |req) lat_we <= we[gnt_next];
      for (int i = 0; i < 2; i++) begin
        if (ack[i] && lat_we && wr_cnt[i*16 +: 16] != 16'hFFFF)
          wr_cnt[i*16 +: 16] <= wr_cnt[i*16 +: 16] + 16'd1;
        if (ack[i] && !lat_we && rd_cnt[i*16 +: 16] != 16'hFFFF)
          rd_cnt[i*16 +: 16] <= rd_cnt[i*16 +: 16] + 16'd1;
      end
      if (|ack && resp != 2'b00 && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
